// File: rtl/io_ready_pkg.sv
// rtl/io_ready_pkg.sv - FSM state encoding and default widths shared by io_ready_ctrl
package io_ready_pkg;

    localparam int SLOT_W_DEF = 3;
    localparam int TO_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_TOUT   = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a parameterized reset value
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_ready_ctrl.sv
// rtl/io_ready_ctrl.sv - Dock I/O wait-state controller; watchdog/TOUT built only with IO_READY_TIMEOUT_EN
module io_ready_ctrl
    import io_ready_pkg::*;
#(
    parameter int NUM_SLOTS   = 5,
    parameter int SLOT_W      = SLOT_W_DEF,
    parameter int MIN_WAIT    = 1,
    parameter int TIMEOUT_CYC = 200,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic                 win_valid,
    input  logic [SLOT_W-1:0]    sel_slot,
    input  logic [NUM_SLOTS-1:0] dev_ready_n,
    input  logic                 err_clr,
    output logic                 ready_n,
    output logic                 cyc_active,
    output logic                 ff_force,
    output logic                 timeout_err,
    output logic [SLOT_W-1:0]    timeout_slot
);

    localparam logic [3:0] WLAST = (MIN_WAIT == 0) ? 4'd0 : 4'(MIN_WAIT - 1);

    logic                 iorq_s;
    logic [NUM_SLOTS-1:0] rdy_s;
    state_t               state, state_nx;
    logic [3:0]           wcnt;
    logic [SLOT_W-1:0]    slot_q;
    logic [1:0]           flush;
    logic                 armed;
    logic                 start, mapped, slot_rdy, wcnt_last, tterm;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_iorq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (iorq_n),
        .q     (iorq_s)
    );

    sync_2ff #(.WIDTH(NUM_SLOTS), .RST_VAL({NUM_SLOTS{1'b1}})) u_rdy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dev_ready_n),
        .q     (rdy_s)
    );

    // A cycle may only start once /IORQ has been seen high through a flushed synchronizer,
    // so a reset in the middle of a cycle never re-enters that same cycle.
    assign start     = (state == ST_IDLE) && armed && !iorq_s;
    assign mapped    = win_valid && (32'(sel_slot) < NUM_SLOTS);
    assign slot_rdy  = rdy_s[slot_q];
    assign wcnt_last = (wcnt == WLAST);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = mapped ? ST_SETTLE : ST_ACK;
            end
            ST_SETTLE: begin
                if (iorq_s)                  state_nx = ST_IDLE;
                else if (tterm && !slot_rdy) state_nx = ST_TOUT;
                else if (wcnt_last)          state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (iorq_s)        state_nx = ST_IDLE;
                else if (slot_rdy) state_nx = ST_ACK;
                else if (tterm)    state_nx = ST_TOUT;
            end
            ST_ACK, ST_TOUT: begin
                if (iorq_s) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            slot_q     <= '0;
            flush      <= '0;
            armed      <= 1'b0;
            ready_n    <= 1'b1;
            cyc_active <= 1'b0;
        end else begin
            state      <= state_nx;
            wcnt       <= (state == ST_SETTLE) ? wcnt + 4'd1 : 4'd0;
            flush      <= {flush[0], 1'b1};
            if (flush[1] && iorq_s) armed <= 1'b1;
            if (start) slot_q <= sel_slot;
            ready_n    <= !(state_nx == ST_SETTLE || state_nx == ST_WAIT);
            cyc_active <= (state_nx != ST_IDLE);
        end
    end

`ifdef IO_READY_TIMEOUT_EN
    logic [TO_W-1:0] tcnt;
    logic            rd_q;

    assign tterm = (tcnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt         <= '0;
            rd_q         <= 1'b0;
            ff_force     <= 1'b0;
            timeout_err  <= 1'b0;
            timeout_slot <= '0;
        end else begin
            tcnt     <= (state == ST_SETTLE || state == ST_WAIT) ? tcnt + 1'b1 : '0;
            if (start) rd_q <= r_w_;
            ff_force <= (state_nx == ST_TOUT) && rd_q;
            // A timeout being raised takes priority over a clear in the same cycle.
            if (state_nx == ST_TOUT && state != ST_TOUT) begin
                timeout_err  <= 1'b1;
                timeout_slot <= slot_q;
            end else if (err_clr) begin
                timeout_err  <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign tterm        = 1'b0;
    assign ff_force     = 1'b0;
    assign timeout_err  = 1'b0;
    assign timeout_slot = '0;
    assign unused_cfg   = ^{err_clr, r_w_, 32'(TIMEOUT_CYC), 32'(TO_W)};
`endif

endmodule

// File: tb/tb_io_ready_ctrl.sv
// tb/tb_io_ready_ctrl.sv - self-checking bench for io_ready_ctrl (both IO_READY_TIMEOUT_EN builds)
module tb_io_ready_ctrl;

    localparam int NUM_SLOTS   = 5;
    localparam int SLOT_W      = 3;
    localparam int MIN_WAIT    = 1;
    localparam int TIMEOUT_CYC = 200;
    localparam int TO_W        = 8;
`ifdef IO_READY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 iorq_n = 1'b1;
    logic                 r_w_ = 1'b0;
    logic                 win_valid = 1'b0;
    logic [SLOT_W-1:0]    sel_slot = '0;
    logic [NUM_SLOTS-1:0] dev_ready_n = '1;
    logic                 err_clr = 1'b0;
    logic                 ready_n, cyc_active, ff_force, timeout_err;
    logic [SLOT_W-1:0]    timeout_slot;

    int                total = 0;
    int                passed = 0;
    bit                err_m = 1'b0;
    logic [SLOT_W-1:0] slot_m = '0;
    int                stray;

    always #5 clk = ~clk;

    io_ready_ctrl #(
        .NUM_SLOTS   (NUM_SLOTS),
        .SLOT_W      (SLOT_W),
        .MIN_WAIT    (MIN_WAIT),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iorq_n       (iorq_n),
        .r_w_         (r_w_),
        .win_valid    (win_valid),
        .sel_slot     (sel_slot),
        .dev_ready_n  (dev_ready_n),
        .err_clr      (err_clr),
        .ready_n      (ready_n),
        .cyc_active   (cyc_active),
        .ff_force     (ff_force),
        .timeout_err  (timeout_err),
        .timeout_slot (timeout_slot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready_n"}, ready_n, 1);
        chk({tag, "_cyc_active"}, cyc_active, 0);
        chk({tag, "_ff_force"}, ff_force, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_timeout_slot"}, timeout_slot, 0);
    endtask

    // One /IORQ cycle: fall before edge 1, selected device released before edge rel,
    // /IORQ released before edge hold+1. Expectations come from the timing rules:
    // ready_n goes low 3 edges after the fall, stays low max(MIN_WAIT+1, rel-1) cycles
    // (release seen via 2-flop sync then one FSM edge), capped by the watchdog and by abort.
    task automatic do_txn(input bit wv, input int slot, input bit rd, input int rel, input int hold);
        bit mapped   = wv && (slot < NUM_SLOTS);
        int low_rdy  = (rel - 1 > MIN_WAIT + 1) ? rel - 1 : MIN_WAIT + 1;
        bit tout     = TO_EN && mapped && (low_rdy > TIMEOUT_CYC) && (hold > TIMEOUT_CYC);
        int low      = (TO_EN && low_rdy > TIMEOUT_CYC) ? TIMEOUT_CYC : low_rdy;
        int last     = (2 + low < hold + 2) ? 2 + low : hold + 2;
        int first_lo = -1;
        int last_lo  = -1;
        int cnt      = 0;
        logic ca_hi = 1'b0, ca_lo = 1'b1, ff_hi = 1'b0, ff_lo = 1'b1;
        for (int e = 1; e <= hold + 4; e++) begin
            @(negedge clk);
            if (e == 1) begin
                iorq_n    = 1'b0;
                r_w_      = rd;
                win_valid = wv;
                sel_slot  = SLOT_W'(slot);
            end
            if (e == hold + 1) iorq_n = 1'b1;
            dev_ready_n = NUM_SLOTS'($urandom);
            if (slot < NUM_SLOTS) dev_ready_n[slot] = (e >= rel);
            @(posedge clk);
            #1;
            if (!ready_n) begin
                cnt++;
                if (first_lo < 0) first_lo = e;
                last_lo = e;
            end
            if (e == hold + 2) begin
                ca_hi = cyc_active;
                ff_hi = ff_force;
            end
            if (e == hold + 3) begin
                ca_lo = cyc_active;
                ff_lo = ff_force;
            end
        end
        if (tout) begin
            err_m  = 1'b1;
            slot_m = SLOT_W'(slot);
        end
        chk("low_count", cnt, mapped ? last - 2 : 0);
        chk("low_first", first_lo, mapped ? 3 : -1);
        chk("low_last", last_lo, mapped ? last : -1);
        chk("cyc_active_held", ca_hi, 1);
        chk("cyc_active_drop", ca_lo, 0);
        chk("ff_force_tout", ff_hi, tout && rd);
        chk("ff_force_idle", ff_lo, 0);
        chk("timeout_err", timeout_err, err_m);
        chk("timeout_slot", timeout_slot, slot_m);
    endtask

    initial begin
        bit wv, rd;
        int slot, rel, lowr, hold;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_txn(1'b1, 0, 1'b0, 0, 10);
        do_txn(1'b1, 1, 1'b1, 23, 28);
        do_txn(1'b0, 2, 1'b1, 100000, 8);
`ifdef IO_READY_TIMEOUT_EN
        do_txn(1'b1, 4, 1'b1, 100000, 205);
`else
        do_txn(1'b1, 4, 1'b1, 262, 266);
`endif
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_m   = 1'b0;
        #1;
        chk("err_clr_cleared", timeout_err, 0);
        chk("err_clr_slot_kept", timeout_slot, slot_m);

        do_txn(1'b1, 3, 1'b0, 201, 205);
        do_txn(1'b1, 3, 1'b1, 100000, 7);

        @(negedge clk);
        iorq_n         = 1'b0;
        win_valid      = 1'b1;
        sel_slot       = 3'd2;
        r_w_           = 1'b1;
        dev_ready_n[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_low", ready_n, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_mid");
        err_m  = 1'b0;
        slot_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (!ready_n || cyc_active) stray++;
        end
        chk("rst_no_restart", stray, 0);
        @(negedge clk);
        iorq_n = 1'b1;
        repeat (4) @(negedge clk);
        do_txn(1'b1, 2, 1'b0, 0, 8);

        for (int i = 0; i < 12; i++) begin
            wv   = ($urandom % 4) != 0;
            slot = int'($urandom % 8);
            rd   = $urandom % 2;
            rel  = int'($urandom_range(0, 30));
            lowr = (rel - 1 > MIN_WAIT + 1) ? rel - 1 : MIN_WAIT + 1;
            hold = 2 + lowr + int'($urandom_range(1, 6));
            do_txn(wv, slot, rd, rel, hold);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
